// File: rtl/gray_ctrl_pkg.sv
// gray_ctrl_pkg: shared types and constants for the Gray sweep sequencer.
package gray_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/binary_gray.sv
// binary_gray: combinational binary to reflected-Gray converter.
module binary_gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] g
);

   assign g = b ^ (b >> 1);

endmodule

// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: sweeps a binary count over [lo, hi] up or down, one-shot
// or wrapping, and streams each value with its Gray code on valid/ready.
// Optional feature macro GRAY_STEP_CHECK_EN adds a sticky step_err output that
// flags consecutive accepted Gray values differing in other than one bit.
module gray_sweep_ctrl
   import gray_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             dir,
   input  logic             wrap,
   input  logic             abort,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_bin,
   output logic [WIDTH-1:0] out_gray,
   output logic             busy,
   output logic             done,
`ifdef GRAY_STEP_CHECK_EN
   output logic             step_err,
`endif
   output logic             cfg_err
);

   state_t           state;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic             dir_q, wrap_q;
   logic [WIDTH-1:0] nxt_bin, nxt_gray;
   logic             xfer, at_end;

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0] prev_gray;
   logic             chk_arm;   // a previous accepted value exists in this pass
`endif

   assign xfer   = out_valid && out_ready;
   // End test uses the current value, so stepping never runs past 0 or 2^W-1.
   assign at_end = (dir_q == DIR_DOWN) ? (out_bin == lo_q) : (out_bin == hi_q);

   // Next count: start endpoint on load/reload, otherwise one step toward the end.
   always_comb begin
      nxt_bin = out_bin;
      if (state == S_IDLE)
         nxt_bin = (dir == DIR_DOWN) ? hi : lo;
      else if (at_end)
         nxt_bin = (dir_q == DIR_DOWN) ? hi_q : lo_q;
      else if (dir_q == DIR_DOWN)
         nxt_bin = out_bin - WIDTH'(1);
      else
         nxt_bin = out_bin + WIDTH'(1);
   end

   binary_gray #(.WIDTH(WIDTH)) u_b2g (
      .b (nxt_bin),
      .g (nxt_gray)
   );

   // Sequencer FSM; all outputs registered, bin and gray load on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         lo_q      <= '0;
         hi_q      <= '0;
         dir_q     <= DIR_UP;
         wrap_q    <= 1'b0;
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_gray  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
`ifdef GRAY_STEP_CHECK_EN
         step_err  <= 1'b0;
         prev_gray <= '0;
         chk_arm   <= 1'b0;
`endif
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (lo > hi) begin
                     cfg_err <= 1'b1;
                  end else begin
                     lo_q      <= lo;
                     hi_q      <= hi;
                     dir_q     <= dir;
                     wrap_q    <= wrap;
                     out_bin   <= nxt_bin;
                     out_gray  <= nxt_gray;
                     out_valid <= 1'b1;
                     busy      <= 1'b1;
                     state     <= S_RUN;
`ifdef GRAY_STEP_CHECK_EN
                     chk_arm   <= 1'b0;
`endif
                  end
               end
            end
            S_RUN: begin
`ifdef GRAY_STEP_CHECK_EN
               // A transfer taken together with abort is still checked.
               if (xfer) begin
                  if (chk_arm && ($countones(out_gray ^ prev_gray) != 1))
                     step_err <= 1'b1;
                  prev_gray <= out_gray;
                  chk_arm   <= !(at_end && wrap_q);
               end
`endif
               if (abort) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (xfer) begin
                  if (!at_end || wrap_q) begin
                     out_bin  <= nxt_bin;
                     out_gray <= nxt_gray;
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
